// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the display-counter sequencer.
package count_seq_pkg;

    localparam int unsigned DIV_W_DEF       = 6;
    localparam int unsigned BASE_CYCLES_DEF = 5_000_000;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2,
        STEP = 2'd3
    } seq_state_e;

endpackage

// File: rtl/count_sequencer_if.sv
// Count-enable bus from the sequencer to the 24-bit counter datapath.
interface count_sequencer_if;

    logic cnt_en;
    logic cnt_up;

    modport master (output cnt_en, output cnt_up);
    modport slave  (input  cnt_en, input  cnt_up);

endinterface

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer for a raw active-low key plus a registered
// falling-edge detector. Flops reset to the released (high) level.
module key_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic evt
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    // Synchronize, delay once more, and flag a 1->0 transition for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            sync2_d <= 1'b1;
            evt     <= 1'b0;
        end else begin
            sync1   <= key_n;
            sync2   <= sync1;
            sync2_d <= sync2;
            evt     <= sync2_d & ~sync2;
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Sequencer for the board up/down counter: turns divide-by, mode switches
// and the step key into a one-cycle count pulse plus a registered direction.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int unsigned BASE_CYCLES = BASE_CYCLES_DEF,
    parameter int unsigned DIV_W       = DIV_W_DEF
) (
    input  logic               MAX10_CLK1_50,
    input  logic               KEY0,
    input  logic [DIV_W-1:0]   divideby,
    input  logic               enable,
    input  logic               up_down,
    input  logic               free_run,
    input  logic               step_n,
    count_sequencer_if.master  cnt,
    output logic               div_zero,
    output logic               heartbeat,
    output logic [1:0]         state
);

    localparam int unsigned BASE_W = (BASE_CYCLES > 1) ? $clog2(BASE_CYCLES) : 1;

    seq_state_e        state_q;
    seq_state_e        next_state;
    logic [BASE_W-1:0] base_cnt;
    logic [BASE_W-1:0] base_cnt_d;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_cnt_d;
    logic [DIV_W-1:0]  div_q;
    logic              base_tick;
    logic              pulse;
    logic              step_evt;
    logic              cnt_en_q;
    logic              cnt_up_q;
    logic              heartbeat_q;
    logic              div_zero_q;

    key_edge_sync u_step_sync (
        .clk   (MAX10_CLK1_50),
        .rst_n (KEY0),
        .key_n (step_n),
        .evt   (step_evt)
    );

    // FSM state register.
    always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q <= HALT;
        end else begin
            state_q <= next_state;
        end
    end

    // Next state, prescaler update and pulse decision. The pulse is only
    // allowed when the FSM stays in its state, so leaving RUN/STEP never
    // emits a trailing pulse and the prescaler freezes on the exit edge.
    always_comb begin
        next_state = state_q;
        base_cnt_d = base_cnt;
        div_cnt_d  = div_cnt;
        pulse      = 1'b0;
        base_tick  = (base_cnt == BASE_W'(BASE_CYCLES - 1));

        if (divideby == '0) begin
            next_state = HALT;
        end else if (!enable) begin
            next_state = HOLD;
        end else if (free_run) begin
            next_state = RUN;
        end else begin
            next_state = STEP;
        end

        case (state_q)
            RUN: begin
                if (next_state == RUN) begin
                    if (divideby != div_q) begin
                        base_cnt_d = '0;
                        div_cnt_d  = '0;
                    end else if (base_tick) begin
                        base_cnt_d = '0;
                        if ((div_cnt + DIV_W'(1)) == divideby) begin
                            pulse     = 1'b1;
                            div_cnt_d = '0;
                        end else begin
                            div_cnt_d = div_cnt + DIV_W'(1);
                        end
                    end else begin
                        base_cnt_d = base_cnt + BASE_W'(1);
                    end
                end
            end
            HOLD: begin
                base_cnt_d = base_cnt;
                div_cnt_d  = div_cnt;
            end
            STEP: begin
                base_cnt_d = '0;
                div_cnt_d  = '0;
                if ((next_state == STEP) && step_evt && !cnt_en_q) begin
                    pulse = 1'b1;
                end
            end
            HALT: begin
                base_cnt_d = '0;
                div_cnt_d  = '0;
            end
        endcase
    end

    // Prescaler counters, divide-by shadow copy and registered outputs.
    always_ff @(posedge MAX10_CLK1_50 or negedge KEY0) begin
        if (!KEY0) begin
            base_cnt    <= '0;
            div_cnt     <= '0;
            div_q       <= '0;
            cnt_en_q    <= 1'b0;
            cnt_up_q    <= 1'b0;
            heartbeat_q <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            base_cnt    <= base_cnt_d;
            div_cnt     <= div_cnt_d;
            div_q       <= divideby;
            cnt_en_q    <= pulse;
            div_zero_q  <= (state_q == HALT);
            if (pulse) begin
                cnt_up_q    <= up_down;
                heartbeat_q <= ~heartbeat_q;
            end
        end
    end

    assign cnt.cnt_en = cnt_en_q;
    assign cnt.cnt_up = cnt_up_q;
    assign heartbeat  = heartbeat_q;
    assign div_zero   = div_zero_q;
    assign state      = state_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed self-checking bench for count_sequencer with BASE_CYCLES=1.
module tb_count_sequencer;

    localparam int unsigned DIV_W = 6;

    logic             clk = 1'b0;
    logic             key0;
    logic [DIV_W-1:0] divideby;
    logic             enable;
    logic             up_down;
    logic             free_run;
    logic             step_n;
    logic             div_zero;
    logic             heartbeat;
    logic [1:0]       state;

    logic             hb_exp;
    int               checks = 0;
    int               errors = 0;

    count_sequencer_if cnt_bus ();

    count_sequencer #(
        .BASE_CYCLES (1),
        .DIV_W       (DIV_W)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .KEY0          (key0),
        .divideby      (divideby),
        .enable        (enable),
        .up_down       (up_down),
        .free_run      (free_run),
        .step_n        (step_n),
        .cnt           (cnt_bus),
        .div_zero      (div_zero),
        .heartbeat     (heartbeat),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clocks; bit i of pat is the expected cnt_en after edge i.
    task automatic cycles(input int n, input logic [31:0] pat, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (pat[i]) hb_exp = ~hb_exp;
            chk($sformatf("%s.cnt_en[%0d]", tag, i), {31'd0, cnt_bus.cnt_en}, {31'd0, pat[i]});
            chk($sformatf("%s.heartbeat[%0d]", tag, i), {31'd0, heartbeat}, {31'd0, hb_exp});
        end
    endtask

    initial begin
        key0     = 1'b0;
        divideby = 6'd3;
        enable   = 1'b1;
        up_down  = 1'b1;
        free_run = 1'b1;
        step_n   = 1'b1;
        hb_exp   = 1'b0;

        // Reset values
        #12;
        chk("rst.cnt_en", {31'd0, cnt_bus.cnt_en}, 32'd0);
        chk("rst.cnt_up", {31'd0, cnt_bus.cnt_up}, 32'd0);
        chk("rst.div_zero", {31'd0, div_zero}, 32'd0);
        chk("rst.heartbeat", {31'd0, heartbeat}, 32'd0);
        chk("rst.state", {30'd0, state}, 32'd0);
        #10;
        key0 = 1'b1;

        // RUN with divideby=3: pulses on RUN edges 3, 6, 9
        cycles(1, 32'b0, "run_entry");
        chk("run_entry.state", {30'd0, state}, 32'd2);
        chk("run_entry.div_zero_lag", {31'd0, div_zero}, 32'd1);
        cycles(9, 32'b1_0010_0100, "run3");
        chk("run3.cnt_up", {31'd0, cnt_bus.cnt_up}, 32'd1);
        chk("run3.div_zero", {31'd0, div_zero}, 32'd0);
        chk("run3.state", {30'd0, state}, 32'd2);

        // HOLD at RUN edge 10 freezes count at 1; resume needs 2 RUN edges
        cycles(1, 32'b0, "run_pre_hold");
        enable = 1'b0;
        cycles(1, 32'b0, "hold_entry");
        chk("hold.state", {30'd0, state}, 32'd1);
        cycles(6, 32'b0, "hold");
        enable = 1'b1;
        cycles(3, 32'b100, "resume");
        chk("resume.state", {30'd0, state}, 32'd2);

        // HALT via divideby=0, then restart with divideby=2
        divideby = 6'd0;
        cycles(1, 32'b0, "halt_entry");
        chk("halt.state", {30'd0, state}, 32'd0);
        chk("halt.div_zero_lag0", {31'd0, div_zero}, 32'd0);
        cycles(1, 32'b0, "halt1");
        chk("halt.div_zero", {31'd0, div_zero}, 32'd1);
        cycles(3, 32'b0, "halt_idle");
        divideby = 6'd2;
        cycles(1, 32'b0, "div2_entry");
        chk("div2.state", {30'd0, state}, 32'd2);
        chk("div2.div_zero_lag", {31'd0, div_zero}, 32'd1);
        cycles(1, 32'b0, "div2_a");
        chk("div2.div_zero", {31'd0, div_zero}, 32'd0);
        cycles(5, 32'b10101, "div2_b");

        // Direction change only lands with the next pulse
        up_down = 1'b0;
        cycles(1, 32'b0, "dir_a");
        chk("dir.cnt_up_held", {31'd0, cnt_bus.cnt_up}, 32'd1);
        cycles(1, 32'b1, "dir_b");
        chk("dir.cnt_up_new", {31'd0, cnt_bus.cnt_up}, 32'd0);

        // divideby 2->5 mid-period: that cycle is suppressed, then 5 clocks
        cycles(1, 32'b0, "chg_a");
        divideby = 6'd5;
        cycles(1, 32'b0, "chg_suppress");
        cycles(5, 32'b10000, "chg_div5");

        // STEP mode with divideby=4
        divideby = 6'd4;
        free_run = 1'b0;
        cycles(1, 32'b0, "step_entry");
        chk("step.state", {30'd0, state}, 32'd3);
        cycles(2, 32'b0, "step_idle");
        step_n = 1'b0;
        cycles(3, 32'b0, "step1_a");
        step_n = 1'b1;
        cycles(7, 32'b0000001, "step1_b");
        step_n = 1'b0;
        cycles(3, 32'b0, "step2_a");
        step_n = 1'b1;
        cycles(7, 32'b0000001, "step2_b");
        step_n = 1'b0;
        cycles(16, 32'b1000, "step3_held");
        step_n = 1'b1;
        cycles(4, 32'b0, "step3_release");
        chk("step.cnt_up", {31'd0, cnt_bus.cnt_up}, 32'd0);

        // Back to RUN, async reset right after a pulse
        divideby = 6'd2;
        up_down  = 1'b1;
        free_run = 1'b1;
        cycles(1, 32'b0, "rerun_entry");
        cycles(2, 32'b10, "rerun");
        #2;
        key0 = 1'b0;
        #1;
        hb_exp = 1'b0;
        chk("arst.cnt_en", {31'd0, cnt_bus.cnt_en}, 32'd0);
        chk("arst.cnt_up", {31'd0, cnt_bus.cnt_up}, 32'd0);
        chk("arst.div_zero", {31'd0, div_zero}, 32'd0);
        chk("arst.heartbeat", {31'd0, heartbeat}, 32'd0);
        chk("arst.state", {30'd0, state}, 32'd0);
        @(posedge clk);
        #3;
        key0 = 1'b1;
        cycles(1, 32'b0, "post_rst_entry");
        chk("post_rst.state", {30'd0, state}, 32'd2);
        cycles(2, 32'b10, "post_rst");
        chk("post_rst.cnt_up", {31'd0, cnt_bus.cnt_up}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
